store_buffer: RTL and testbench

Write buffer between the single-cycle RV64 core's store port and data memory. The core enqueues doubleword-aligned stores and continues without waiting. The buffer drains entries in order to memory over a req/ack handshake. It also checks core loads against pending stores, so a load never reads stale data.

---
 rtl/store_buffer.sv | 140 ++++++++++++++
 tb/tb_store_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
//==============================================================================
// Module   : store_buffer
// Purpose  : In-order write buffer between the RV64 core store port and data
//            memory. Stores are queued without stalling the core, drained to
//            memory one per req/ack handshake, and core loads are checked
//            against pending entries so they never observe stale data.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            st_valid/st_ready   - store enqueue handshake
//            st_addr/data/mask   - store payload (dword aligned, bits [2:0] ignored)
//            ld_check/ld_addr    - load address to check against pending stores
//            ld_hit              - load must stall
//            ld_fwd_valid/data   - forwarded load result (forwarding build only)
//            mem_req/addr/data/mask, mem_ack - drain handshake to memory
//            empty               - no pending stores
// Config   : define STORE_BUF_FWD_EN to forward full-mask youngest matches.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 64,
   parameter int DW    = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            st_valid,
   output logic            st_ready,
   input  logic [AW-1:0]   st_addr,
   input  logic [DW-1:0]   st_data,
   input  logic [DW/8-1:0] st_mask,
   input  logic            ld_check,
   input  logic [AW-1:0]   ld_addr,
   output logic            ld_hit,
   output logic            ld_fwd_valid,
   output logic [DW-1:0]   ld_fwd_data,
   output logic            mem_req,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_data,
   output logic [DW/8-1:0] mem_mask,
   input  logic            mem_ack,
   output logic            empty
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [AW-4:0]   addr_q [DEPTH];
   logic [DW-1:0]   data_q [DEPTH];
   logic [DW/8-1:0] mask_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic push;
   logic pop;

   // Byte-offset bits of both addresses are intentionally ignored.
   logic unused;
   assign unused = &{1'b0, st_addr[2:0], ld_addr[2:0]};

   // Readiness depends only on registered count: a pop in the same cycle
   // never frees a slot for a store arriving while full.
   assign st_ready = (count != FULL);
   assign empty    = (count == '0);
   assign mem_req  = (count != '0);
   assign push     = st_valid && st_ready;
   assign pop      = mem_req && mem_ack;

   // Head payload is presented directly; zeroed while idle.
   assign mem_addr = mem_req ? {addr_q[head], 3'b000} : '0;
   assign mem_data = mem_req ? data_q[head] : '0;
   assign mem_mask = mem_req ? mask_q[head] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: entries are only observed while valid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= st_addr[AW-1:3];
         data_q[tail] <= st_data;
         mask_q[tail] <= st_mask;
      end
   end

   // Scan from oldest to youngest so the last match is the youngest one.
   logic          match_any;
   logic [PW-1:0] idx;
`ifdef STORE_BUF_FWD_EN
   logic [PW-1:0] young;
`endif

   always_comb begin
      match_any = 1'b0;
      idx       = head;
`ifdef STORE_BUF_FWD_EN
      young     = head;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((CW'(k) < count) && ld_check && (addr_q[idx] == ld_addr[AW-1:3])) begin
            match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
            young     = idx;
`endif
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic fwd_ok;
   assign fwd_ok       = match_any && (mask_q[young] == {(DW/8){1'b1}});
   assign ld_fwd_valid = fwd_ok;
   assign ld_fwd_data  = fwd_ok ? data_q[young] : '0;
   assign ld_hit       = match_any && !fwd_ok;
`else
   assign ld_fwd_valid = 1'b0;
   assign ld_fwd_data  = '0;
   assign ld_hit       = match_any;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none

module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [7:0]  st_mask;
   logic        ld_check;
   logic [63:0] ld_addr;
   logic        ld_hit;
   logic        ld_fwd_valid;
   logic [63:0] ld_fwd_data;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [63:0] mem_data;
   logic [7:0]  mem_mask;
   logic        mem_ack;
   logic        empty;

   store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_mask(st_mask),
      .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit),
      .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_mask(mem_mask), .mem_ack(mem_ack), .empty(empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   typedef struct {
      logic [60:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } entry_t;

   entry_t q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of pending stores.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         started = 1;
      end else if (started) begin
         bit do_pop, do_push;
         entry_t e;
         do_pop  = (q.size() != 0) && mem_ack;
         do_push = st_valid && (q.size() != 4);
         e.addr = st_addr[63:3];
         e.data = st_data;
         e.mask = st_mask;
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         logic        e_hit, e_fv;
         logic [63:0] e_fd;
         bit          found;
         int          y;
         found = 0; y = 0;
         e_hit = 0; e_fv = 0; e_fd = '0;
         foreach (q[i])
            if (ld_check && q[i].addr == ld_addr[63:3]) begin
               found = 1;
               y = i;
            end
`ifdef STORE_BUF_FWD_EN
         if (found) begin
            if (q[y].mask == 8'hFF) begin
               e_fv = 1;
               e_fd = q[y].data;
            end else begin
               e_hit = 1;
            end
         end
`else
         e_hit = found;
`endif
         check("st_ready", st_ready, q.size() != 4);
         check("empty", empty, q.size() == 0);
         check("mem_req", mem_req, q.size() != 0);
         check("mem_addr", mem_addr, q.size() ? {q[0].addr, 3'b000} : 64'd0);
         check("mem_data", mem_data, q.size() ? q[0].data : 64'd0);
         check("mem_mask", mem_mask, q.size() ? q[0].mask : 8'd0);
         check("ld_hit", ld_hit, e_hit);
         check("ld_fwd_valid", ld_fwd_valid, e_fv);
         check("ld_fwd_data", ld_fwd_data, e_fd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_st(input logic v, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
      st_valid = v; st_addr = a; st_data = d; st_mask = m;
   endtask

   initial begin
      rst = 1; mem_ack = 0; ld_check = 0; ld_addr = '0;
      set_st(0, '0, '0, '0);
      tick(); tick();
      rst = 0;
      @(negedge clk);
      check("rst_st_ready", st_ready, 1);
      check("rst_empty", empty, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_ld_hit", ld_hit, 0);
      check("rst_fwd_valid", ld_fwd_valid, 0);
      check("rst_mem_addr", mem_addr, 0);

      // Single store, drained with ack held high.
      set_st(1, 64'h80001004, 64'h1122334455667788, 8'hF0);
      mem_ack = 1;
      tick();
      st_valid = 0;
      @(negedge clk);
      check("t1_mem_req", mem_req, 1);
      check("t1_mem_addr", mem_addr, 64'h80001000);
      check("t1_mem_mask", mem_mask, 8'hF0);
      check("t1_mem_data", mem_data, 64'h1122334455667788);
      tick();
      @(negedge clk);
      check("t1_empty", empty, 1);

      // Fill to full, then pop one.
      mem_ack = 0;
      for (int i = 0; i < 4; i++) begin
         set_st(1, 64'h80000000 + 64'(8 * i), 64'hA0 + 64'(i), 8'hFF);
         tick();
      end
      st_valid = 0;
      @(negedge clk);
      check("t2_full_ready", st_ready, 0);
      check("t2_head0", mem_addr, 64'h80000000);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      @(negedge clk);
      check("t2_ready_after_pop", st_ready, 1);
      check("t2_head1", mem_addr, 64'h80000008);
      set_st(1, 64'h80000040, 64'h40, 8'h01);
      tick();
      @(negedge clk);
      check("t3_full", st_ready, 0);
      // Full with st_valid and mem_ack together: pop only.
      set_st(1, 64'h80000048, 64'h48, 8'h02);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      @(negedge clk);
      check("t3_no_bypass", st_ready, 1);
      check("t3_head2", mem_addr, 64'h80000010);
      tick();
      st_valid = 0;
      @(negedge clk);
      check("t3_accepted_next", st_ready, 0);
      mem_ack = 1;
      begin
         logic [63:0] exp_a [4];
         exp_a[0] = 64'h80000010; exp_a[1] = 64'h80000018;
         exp_a[2] = 64'h80000040; exp_a[3] = 64'h80000048;
         for (int i = 0; i < 4; i++) begin
            check("t3_order", mem_addr, exp_a[i]);
            tick();
            @(negedge clk);
         end
      end
      check("t3_drained", empty, 1);
      mem_ack = 0;

      // Load conflict check.
      set_st(1, 64'h80002000, 64'h55, 8'h0F);
      tick();
      st_valid = 0;
      ld_check = 1;
      ld_addr = 64'h80002004;
      @(negedge clk);
      check("t4_hit", ld_hit, 1);
      check("t4_hit_nofwd", ld_fwd_valid, 0);
      tick();
      ld_addr = 64'h80002008;
      @(negedge clk);
      check("t4_miss", ld_hit, 0);
      tick();
      ld_addr = 64'h80002004;
      mem_ack = 1;
      tick();
      mem_ack = 0;
      @(negedge clk);
      check("t4_after_pop", ld_hit, 0);
      ld_check = 0;

      // Two full-mask stores to the same dword.
      set_st(1, 64'h80003000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      tick();
      set_st(1, 64'h80003000, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
      tick();
      st_valid = 0;
      ld_check = 1;
      ld_addr = 64'h80003000;
      @(negedge clk);
`ifdef STORE_BUF_FWD_EN
      check("t5_fwd_valid", ld_fwd_valid, 1);
      check("t5_fwd_data", ld_fwd_data, 64'hBBBB_BBBB_BBBB_BBBB);
      check("t5_hit", ld_hit, 0);
`else
      check("t5_hit", ld_hit, 1);
      check("t5_fwd_valid", ld_fwd_valid, 0);
`endif
      ld_check = 0;
      mem_ack = 1;
      tick(); tick();
      mem_ack = 0;

      // Reset with three pending entries and ack high.
      for (int i = 0; i < 3; i++) begin
         set_st(1, 64'h80004000 + 64'(8 * i), 64'(i), 8'hFF);
         tick();
      end
      st_valid = 0;
      rst = 1;
      mem_ack = 1;
      @(negedge clk);
      check("t6_req_before", mem_req, 1);
      tick();
      rst = 0;
      @(negedge clk);
      check("t6_empty", empty, 1);
      check("t6_mem_req", mem_req, 0);
      check("t6_st_ready", st_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check("t6_no_req", mem_req, 0);
      end
      mem_ack = 0;

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst      = ($urandom_range(0, 299) == 0);
         st_valid = $urandom_range(0, 1);
         st_addr  = 64'h80000000 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
         st_data  = {$urandom, $urandom};
         st_mask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         ld_check = $urandom_range(0, 1);
         ld_addr  = 64'h80000000 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
         mem_ack  = ($urandom_range(0, 2) == 0);
      end
      tick();
      rst = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
